// File: rtl/pulse_rate_pkg.sv
// Shared defaults and width helper for the pulse rate meter.
package pulse_rate_pkg;

  localparam int unsigned DEF_CNT_W          = 8;
  localparam int unsigned DEF_WIN_CYCLES     = 50_000_000;
  localparam int unsigned DEF_REFRACT_CYCLES = 1000;
  localparam int unsigned DEF_IDLE_WINDOWS   = 3;
  localparam int unsigned DEF_AVG_DEPTH      = 4;

  // Bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'(1) << width) < 64'(value)) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Beat input conditioning: 2-FF synchroniser, rising-edge detect and refractory
// hold-off. Emits a one-cycle beat strobe per accepted edge.
module pulse_sync_edge
  import pulse_rate_pkg::*;
#(
  parameter int unsigned REFRACT_CYCLES = DEF_REFRACT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic pulse_in,
  output logic beat
);

  localparam int unsigned REFR_W = (clog2(REFRACT_CYCLES) < 1) ? 1 : clog2(REFRACT_CYCLES);
  localparam logic [REFR_W-1:0] REFR_LOAD =
      (REFRACT_CYCLES == 0) ? '0 : REFR_W'(REFRACT_CYCLES - 1);

  logic              sync1;
  logic              sync2;
  logic              prev;
  logic [REFR_W-1:0] refr_cnt;

  // Only the registered refr_cnt is consulted, so an edge coinciding with expiry waits.
  always_comb begin
    beat = en & sync2 & ~prev & (refr_cnt == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
      refr_cnt <= '0;
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
      prev  <= sync2;
      if (!en) begin
        refr_cnt <= '0;
      end else if (beat) begin
        refr_cnt <= REFR_LOAD;
      end else if (refr_cnt != '0) begin
        refr_cnt <= refr_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_rate_meter.sv
// Beat rate meter: window timer, saturating beat counter, overflow/no-pulse alarms.
// Define PULSE_RATE_AVG_EN to publish an AVG_DEPTH-window moving average as rate.
module pulse_rate_meter
  import pulse_rate_pkg::*;
#(
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned WIN_CYCLES     = DEF_WIN_CYCLES,
  parameter int unsigned REFRACT_CYCLES = DEF_REFRACT_CYCLES,
  parameter int unsigned IDLE_WINDOWS   = DEF_IDLE_WINDOWS,
  parameter int unsigned AVG_DEPTH      = DEF_AVG_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic             overflow,
  output logic             no_pulse
);

  localparam int unsigned WIN_W  = clog2(WIN_CYCLES);
  localparam int unsigned IDLE_W = clog2(IDLE_WINDOWS + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_WINDOWS);

  logic              beat;
  logic              terminal;
  logic [WIN_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              sat;
  logic              sat_next;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_next;

  pulse_sync_edge #(
    .REFRACT_CYCLES(REFRACT_CYCLES)
  ) u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .pulse_in(pulse_in),
    .beat    (beat)
  );

  // count_next folds in a beat landing in the terminal cycle itself.
  always_comb begin
    terminal   = en && (win_cnt == WIN_LAST);
    count_next = count;
    sat_next   = sat;
    if (beat) begin
      if (count == '1) begin
        sat_next = 1'b1;
      end else begin
        count_next = count + 1'b1;
      end
    end
    if (count_next != '0) begin
      idle_next = '0;
    end else if (idle_cnt == IDLE_MAX) begin
      idle_next = idle_cnt;
    end else begin
      idle_next = idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt    <= '0;
      count      <= '0;
      sat        <= 1'b0;
      idle_cnt   <= '0;
      rate_valid <= 1'b0;
      overflow   <= 1'b0;
      no_pulse   <= 1'b0;
    end else if (!en) begin
      win_cnt    <= '0;
      count      <= '0;
      sat        <= 1'b0;
      rate_valid <= 1'b0;
    end else if (terminal) begin
      win_cnt    <= '0;
      count      <= '0;
      sat        <= 1'b0;
      idle_cnt   <= idle_next;
      rate_valid <= 1'b1;
      overflow   <= sat_next;
      no_pulse   <= (idle_next == IDLE_MAX);
    end else begin
      win_cnt    <= win_cnt + 1'b1;
      count      <= count_next;
      sat        <= sat_next;
      rate_valid <= 1'b0;
    end
  end

`ifdef PULSE_RATE_AVG_EN
  localparam int unsigned AVG_LOG = clog2(AVG_DEPTH);
  localparam int unsigned SUM_W   = CNT_W + AVG_LOG;

  logic [CNT_W-1:0] avg_buf [AVG_DEPTH];
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sum_next;

  always_comb begin
    sum_next = sum + SUM_W'(count_next) - SUM_W'(avg_buf[AVG_DEPTH-1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        avg_buf[i] <= '0;
      end
      sum  <= '0;
      rate <= '0;
    end else if (terminal) begin
      for (int i = AVG_DEPTH - 1; i > 0; i--) begin
        avg_buf[i] <= avg_buf[i-1];
      end
      avg_buf[0] <= count_next;
      sum        <= sum_next;
      rate       <= CNT_W'(sum_next >> AVG_LOG);
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate <= '0;
    end else if (terminal) begin
      rate <= count_next;
    end
  end

  // AVG_DEPTH only shapes the averager; nothing is built from it here.
  if (AVG_DEPTH == 0) begin : g_avg_depth_unused
  end
`endif

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Scoreboard bench for pulse_rate_meter: stimulus pushes per-window expectations,
// a negedge monitor pops and compares on every rate_valid strobe.
module tb_pulse_rate_meter;

  localparam int unsigned CNT_W          = 4;
  localparam int unsigned WIN_CYCLES     = 100;
  localparam int unsigned REFRACT_CYCLES = 4;
  localparam int unsigned IDLE_WINDOWS   = 2;
  localparam int unsigned AVG_DEPTH      = 4;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             en    = 1'b0;
  logic             pulse = 1'b0;
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic             overflow;
  logic             no_pulse;

  typedef struct {
    int    rate;
    int    ovf;
    int    np;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass     = 0;
  int   n_total    = 0;
  int   hist[4];
  int   last_rate  = 0;
  bit   prev_valid = 1'b0;

  pulse_rate_meter #(
    .CNT_W         (CNT_W),
    .WIN_CYCLES    (WIN_CYCLES),
    .REFRACT_CYCLES(REFRACT_CYCLES),
    .IDLE_WINDOWS  (IDLE_WINDOWS),
    .AVG_DEPTH     (AVG_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .pulse_in  (pulse),
    .rate      (rate),
    .rate_valid(rate_valid),
    .overflow  (overflow),
    .no_pulse  (no_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 4; i++) hist[i] = 0;
    last_rate = 0;
  endtask

  // Queue the result expected at the close of the window about to run.
  task automatic push_exp(input string name, input int raw, input int ovf, input int np);
    exp_t e;
    int   r;
`ifdef PULSE_RATE_AVG_EN
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = raw;
    r = (hist[0] + hist[1] + hist[2] + hist[3]) >> 2;
`else
    r = raw;
`endif
    e.rate = r;
    e.ovf  = ovf;
    e.np   = np;
    e.name = name;
    sb.push_back(e);
    last_rate = r;
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    repeat (n) begin
      pulse = 1'b1;
      tick(hi);
      pulse = 1'b0;
      tick(lo);
    end
  endtask

  task automatic do_reset();
    en    = 1'b0;
    reset = 1'b1;
    tick(2);
    check("rst_rate", rate, 0);
    check("rst_valid", rate_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_no_pulse", no_pulse, 0);
    reset = 1'b0;
    clear_hist();
    tick(1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (prev_valid) check("valid_one_cycle", rate_valid, 0);
      if (rate_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", rate_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_rate"}, rate, mon_e.rate);
          check({mon_e.name, "_overflow"}, overflow, mon_e.ovf);
          check({mon_e.name, "_no_pulse"}, no_pulse, mon_e.np);
        end
      end
      prev_valid = rate_valid;
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation ran past its time limit, sb=%0d", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_hist();
    // Reset held while the beat input toggles.
    for (int i = 0; i < 6; i++) begin
      pulse = ~pulse;
      tick(1);
    end
    check("t1_rate", rate, 0);
    check("t1_valid", rate_valid, 0);
    check("t1_overflow", overflow, 0);
    check("t1_no_pulse", no_pulse, 0);
    pulse = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
    en = 1'b1;

    // Five clean pulses.
    push_exp("t2_clean5", 5, 0, 0);
    pulses(5, 10, 10);

    // Bounce: edges at offsets 0 and 2 collapse to one beat; edge at 6 is a new beat.
    push_exp("t3_bounce", 2, 0, 0);
    pulse = 1'b1; tick(1);
    pulse = 1'b0; tick(1);
    pulse = 1'b1; tick(3);
    pulse = 1'b0; tick(1);
    pulse = 1'b1; tick(5);
    pulse = 1'b0; tick(89);

    // Twenty beats saturate at 15, then a normal window clears overflow.
    push_exp("t4_sat", 15, 1, 0);
    pulses(20, 2, 3);
    push_exp("t4_after", 3, 0, 0);
    pulses(3, 10, 10);
    tick(40);

    // Two silent windows raise no_pulse; one beat clears it.
    push_exp("t5_idle1", 0, 0, 0);
    tick(100);
    push_exp("t5_idle2", 0, 0, 1);
    tick(100);
    push_exp("t5_beat", 1, 0, 0);
    pulses(1, 10, 10);
    tick(80);

    // en drops mid-window after three beats: count discarded, outputs held.
    pulses(3, 5, 5);
    tick(20);
    en = 1'b0;
    tick(10);
    check("t6_en_rate_hold", rate, last_rate);
    check("t6_en_valid", rate_valid, 0);
    check("t6_en_overflow", overflow, 0);
    check("t6_en_no_pulse", no_pulse, 0);
    en = 1'b1;
    push_exp("t6_en_fresh", 0, 0, 0);
    tick(100);

    // Reset mid-window after three beats.
    pulses(3, 5, 5);
    tick(20);
    do_reset();
    en = 1'b1;
    push_exp("t6_rst_fresh", 2, 0, 0);
    pulses(2, 10, 10);
    tick(60);

`ifdef PULSE_RATE_AVG_EN
    do_reset();
    en = 1'b1;
    push_exp("avg_w4a", 4, 0, 0);
    pulses(4, 10, 10);
    tick(20);
    push_exp("avg_w8a", 8, 0, 0);
    pulses(8, 5, 5);
    tick(20);
    push_exp("avg_w4b", 4, 0, 0);
    pulses(4, 10, 10);
    tick(20);
    push_exp("avg_w8b", 8, 0, 0);
    pulses(8, 5, 5);
    tick(20);
`endif

    tick(3);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
